jc_block_nested: RTL
====================

// Module: jc_block_nested
// PURPOSE
//  Jump-control unit for the MIPS-style datapath: decodes jump/branch/return
//  opcodes and N prioritised interrupt lines, and drives the PC mux select and
//  target. Supports nested interrupts through a return-address/flag stack.
//  Sits between program-memory fetch and the PC register.
// PARAMETERS
//  ADDR_W      16       PC/address width
//  FLAG_W      2        flag_ex width; bit0 = Z, bit1 = C
//  N_IRQ       4        interrupt channels; index 0 = highest priority
//  STACK_DEPTH 4        nesting depth of the return stack (>=1)
//  VEC_BASE    'hF000   vector of channel 0
//  VEC_STRIDE  'h0004   vector spacing; channel i vectors to VEC_BASE + i*VEC_STRIDE
// PORTS
//  clk              in   1        clock, rising edge
//  reset            in   1        asynchronous, active-low
//  jmp_address_pm   in   ADDR_W   jump target from program memory
//  current_address  in   ADDR_W   address of the instruction in decode
//  op               in   6        opcode in decode
//  flag_ex          in   FLAG_W   flags from the execute stage
//  irq              in   N_IRQ    interrupt request lines, level, synchronous to clk
//  irq_mask         in   N_IRQ    1 = channel masked
//  jmp_loc          out  ADDR_W   PC target when pc_mux_sel = 1
//  pc_mux_sel       out  1        1 = load jmp_loc into PC
//  flag_restore     out  FLAG_W   flags popped by RET
//  flag_restore_en  out  1        1-cycle strobe: execute must load flag_restore
//  irq_ack          out  N_IRQ    1-cycle one-hot strobe when a channel is taken
//  stack_err        out  1        1-cycle strobe on RET with an empty stack
// BEHAVIOUR
//  - Reset (async): stack empty, pending and in-service cleared, every output 0.
//  - Pending: pending[i] sets on an irq[i] rising edge (prev-sample register).
//    It clears on ack. A masked channel stays pending.
//  - Eligible: pending & ~irq_mask & channels of strictly higher priority than
//    the highest in-service channel. With nothing in service, all channels qualify.
//  - Take: an eligible channel exists and the stack is not full, so the lowest
//    eligible index k is taken. The same cycle is combinational, zero latency:
//    pc_mux_sel = 1, jmp_loc = VEC_BASE + k*VEC_STRIDE, irq_ack[k] = 1.
//    On the clock edge: push {current_address, flag_ex}, set in_service[k],
//    clear pending[k].
//  - Priority when no interrupt is taken:
//    - JMP  6'h18: sel = 1, loc = jmp_address_pm.
//    - JZ   6'h10: sel = flag_ex[0].
//    - JNZ  6'h11: sel = ~flag_ex[0].
//    - JC   6'h12: sel = flag_ex[1].
//    - JNC  6'h13: sel = ~flag_ex[1].
//    - RET  6'h1E, stack non-empty: sel = 1, loc = top.addr,
//      flag_restore = top.flags, flag_restore_en = 1. On the edge: pop, and
//      clear the highest-priority in_service bit.
//    - RET, stack empty: sel = 0, stack_err = 1, no state change.
//    - Any other op: sel = 0, jmp_loc = 0.
//  - An interrupt taken in a RET cycle wins: the RET is not executed and no pop
//    occurs. Software re-fetches it after the handler returns.
//  - Stack full: interrupts stay pending and are taken after a RET frees an entry.
//  - Simultaneous rising edges: all latch as pending; they are served in index
//    order, one take per cycle.
//  - Address arithmetic is modulo 2^ADDR_W; vector computation truncates silently.
//  - Reset asserted mid-handler discards the stack and all pending state immediately.
// STRUCTURE
//  - Package jc_pkg: opcode localparams (OP_JMP, OP_JZ, OP_JNZ, OP_JC, OP_JNC,
//    OP_RET) and the flag bit indices.
//  - One sub-module, jc_ret_stack: a LIFO of STACK_DEPTH x (ADDR_W+FLAG_W) with
//    push/pop/full/empty/top.
//  - Priority encoder, pending/in-service registers and decode logic stay in the top.
// TESTING
//  1. Reset low for 8 ns then high, with op = 0 -> all outputs 0, stack empty.
//  2. irq[0] rises at current_address = 'h0001 -> same cycle: sel = 1, jmp_loc =
//     'hF000, irq_ack = 'b0001. Then op = 6'h1E -> jmp_loc = 'h0001, flag_restore =
//     the flags at entry, flag_restore_en = 1.
//  3. op = 6'h18, jmp_address_pm = 'h0008 -> sel = 1, jmp_loc = 'h0008.
//     op = 6'h10 with flag_ex = 0 -> sel = 0; with flag_ex = 1 -> sel = 1.
//  4. Nesting: irq[2] taken (jmp_loc = 'hF008); then irq[3] -> stays pending;
//    then irq[1] -> preempts (jmp_loc = 'hF004). Two RETs return in LIFO order,
//    then irq[3] is taken ('hF00C).
//  5. Fill the stack (4 takes at rising priority): a 5th request is not acked
//    until a RET. A RET on an empty stack -> stack_err = 1, sel = 0.
//  6. Masked irq[1] -> no ack; unmask -> ack next cycle. Reset pulse mid-handler
//    -> pending, stack and in_service all cleared.

Source files
------------

// File: rtl/jc_block_nested_pkg.sv
// Shared opcode and flag definitions for the jump-control unit.
package jc_pkg;

  // Decode opcodes understood by the jump-control unit
  localparam logic [5:0] OP_JZ  = 6'h10;
  localparam logic [5:0] OP_JNZ = 6'h11;
  localparam logic [5:0] OP_JC  = 6'h12;
  localparam logic [5:0] OP_JNC = 6'h13;
  localparam logic [5:0] OP_JMP = 6'h18;
  localparam logic [5:0] OP_RET = 6'h1E;

  // Bit positions inside flag_ex / flag_restore
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;

endpackage

// File: rtl/jc_block_nested_if.sv
// Decode-stage bus of the jump-control unit.
// There is no valid/ready handshake: every clock is one decode slot. The
// inputs describe the instruction in decode for that cycle, and the outputs
// are combinational from those inputs plus registered state, so the PC mux
// sees the result in the same cycle. The dbg_* signals expose internal state.
interface jc_block_nested_if #(
  parameter int ADDR_W      = 16,
  parameter int FLAG_W      = 2,
  parameter int N_IRQ       = 4,
  parameter int STACK_DEPTH = 4
);
  localparam int CNT_W = $clog2(STACK_DEPTH + 1);

  logic [ADDR_W-1:0] jmp_address_pm;
  logic [ADDR_W-1:0] current_address;
  logic [5:0]        op;
  logic [FLAG_W-1:0] flag_ex;
  logic [N_IRQ-1:0]  irq;
  logic [N_IRQ-1:0]  irq_mask;

  logic [ADDR_W-1:0] jmp_loc;
  logic              pc_mux_sel;
  logic [FLAG_W-1:0] flag_restore;
  logic              flag_restore_en;
  logic [N_IRQ-1:0]  irq_ack;
  logic              stack_err;

  logic [N_IRQ-1:0]  dbg_pending;
  logic [N_IRQ-1:0]  dbg_in_service;
  logic [CNT_W-1:0]  dbg_depth;

  modport master (
    output jmp_address_pm, current_address, op, flag_ex, irq, irq_mask,
    input  jmp_loc, pc_mux_sel, flag_restore, flag_restore_en, irq_ack, stack_err,
    input  dbg_pending, dbg_in_service, dbg_depth
  );

  modport slave (
    input  jmp_address_pm, current_address, op, flag_ex, irq, irq_mask,
    output jmp_loc, pc_mux_sel, flag_restore, flag_restore_en, irq_ack, stack_err,
    output dbg_pending, dbg_in_service, dbg_depth
  );
endinterface

// File: rtl/jc_block_nested_ret_stack.sv
// Return stack: LIFO of {return address, flags} frames for nested interrupts.
// Reset only clears the occupancy count; stale entries are unreachable.
module jc_ret_stack #(
  parameter int W     = 18,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [W-1:0]                 wdata_i,
  output logic [W-1:0]                 top_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  assign wr_ptr  = PTR_W'(count_q);
  assign rd_ptr  = PTR_W'(count_q - CNT_W'(1));
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign top_o   = mem_q[rd_ptr];
  assign count_o = count_q;

  // Next occupancy and storage contents; push and pop are never requested together
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push_i && !full_o) begin
      mem_d[wr_ptr] = wdata_i;
      count_d       = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_d       = count_q - CNT_W'(1);
    end
  end

  // Occupancy register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Frame storage, no reset needed
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: rtl/jc_block_nested.sv
// Jump-control unit: decodes jumps/branches/returns and prioritised interrupts
// and drives the PC mux. Nested interrupts save {address, flags} on a stack.
module jc_block_nested
  import jc_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          FLAG_W      = 2,
  parameter int          N_IRQ       = 4,
  parameter int          STACK_DEPTH = 4,
  parameter int unsigned VEC_BASE    = 32'hF000,
  parameter int unsigned VEC_STRIDE  = 32'h0004
) (
  input  logic             clk,
  input  logic             reset,
  jc_block_nested_if.slave bus
);
  localparam int ENTRY_W = ADDR_W + FLAG_W;
  localparam int CNT_W   = $clog2(STACK_DEPTH + 1);

  logic [N_IRQ-1:0]   irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]   pending_q, pending_d;
  logic [N_IRQ-1:0]   in_service_q, in_service_d;
  logic [N_IRQ-1:0]   pend_now, allow, eligible, take_oh, isvc_low_oh;
  logic               take;
  logic [ADDR_W-1:0]  vec_loc;
  logic               push, pop;
  logic [ENTRY_W-1:0] top_entry;
  logic               full, empty;
  logic [CNT_W-1:0]   depth;

  // A rising edge this cycle counts as pending immediately so it can be taken now
  assign pend_now = pending_q | (bus.irq & ~irq_prev_q);

  // Channel i may preempt only if no channel at index <= i is in service
  always_comb begin
    logic blocked;
    blocked = 1'b0;
    allow   = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      blocked  = blocked | in_service_q[i];
      allow[i] = ~blocked;
    end
  end

  assign eligible = pend_now & ~bus.irq_mask & allow;
  assign take     = (|eligible) & ~full;

  // Lowest eligible index wins; vector address wraps at ADDR_W bits
  always_comb begin
    take_oh = '0;
    vec_loc = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        take_oh    = '0;
        take_oh[i] = 1'b1;
        vec_loc    = ADDR_W'(VEC_BASE + 32'(i) * VEC_STRIDE);
      end
    end
  end

  // Highest-priority in-service channel, the one a RET retires
  always_comb begin
    isvc_low_oh = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (in_service_q[i]) begin
        isvc_low_oh    = '0;
        isvc_low_oh[i] = 1'b1;
      end
    end
  end

  // Output decode: a taken interrupt overrides whatever op is in decode
  always_comb begin
    bus.pc_mux_sel      = 1'b0;
    bus.jmp_loc         = '0;
    bus.flag_restore    = '0;
    bus.flag_restore_en = 1'b0;
    bus.irq_ack         = '0;
    bus.stack_err       = 1'b0;
    push                = 1'b0;
    pop                 = 1'b0;
    if (take) begin
      bus.pc_mux_sel = 1'b1;
      bus.jmp_loc    = vec_loc;
      bus.irq_ack    = take_oh;
      push           = 1'b1;
    end else begin
      case (bus.op)
        OP_JMP: begin
          bus.pc_mux_sel = 1'b1;
          bus.jmp_loc    = bus.jmp_address_pm;
        end
        OP_JZ: begin
          bus.pc_mux_sel = bus.flag_ex[FLAG_Z];
          bus.jmp_loc    = bus.jmp_address_pm;
        end
        OP_JNZ: begin
          bus.pc_mux_sel = ~bus.flag_ex[FLAG_Z];
          bus.jmp_loc    = bus.jmp_address_pm;
        end
        OP_JC: begin
          bus.pc_mux_sel = bus.flag_ex[FLAG_C];
          bus.jmp_loc    = bus.jmp_address_pm;
        end
        OP_JNC: begin
          bus.pc_mux_sel = ~bus.flag_ex[FLAG_C];
          bus.jmp_loc    = bus.jmp_address_pm;
        end
        OP_RET: begin
          if (!empty) begin
            bus.pc_mux_sel      = 1'b1;
            bus.jmp_loc         = top_entry[ENTRY_W-1:FLAG_W];
            bus.flag_restore    = top_entry[FLAG_W-1:0];
            bus.flag_restore_en = 1'b1;
            pop                 = 1'b1;
          end else begin
            bus.stack_err       = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next pending / in-service / edge-detect state
  always_comb begin
    irq_prev_d   = bus.irq;
    pending_d    = pend_now & ~(take ? take_oh : '0);
    in_service_d = in_service_q;
    if (take)     in_service_d = in_service_q | take_oh;
    else if (pop) in_service_d = in_service_q & ~isvc_low_oh;
  end

  // Interrupt bookkeeping registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_prev_q   <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
    end else begin
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
    end
  end

  jc_ret_stack #(
    .W     (ENTRY_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({bus.current_address, bus.flag_ex}),
    .top_o   (top_entry),
    .full_o  (full),
    .empty_o (empty),
    .count_o (depth)
  );

  assign bus.dbg_pending    = pending_q;
  assign bus.dbg_in_service = in_service_q;
  assign bus.dbg_depth      = depth;
endmodule
